// File: rtl/parameterized_counter.sv
// N-bit free-running up-counter with synchronous parallel load and async reset.
// Optional registered wrap pulse enabled by defining PARAMETERIZED_COUNTER_WRAP_FLAG_EN.
module parameterized_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_en,
  input  logic [N-1:0] data_in,
`ifdef PARAMETERIZED_COUNTER_WRAP_FLAG_EN
  output logic         wrap_out,
`endif
  output logic [N-1:0] count_out
);

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;

  // Load takes priority over increment; increment wraps naturally modulo 2^N.
  always_comb begin
    count_d = count_q + {{(N-1){1'b0}}, 1'b1};
    if (load_en) begin
      count_d = data_in;
    end
  end

  // reset_n is active-high despite its name.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

`ifdef PARAMETERIZED_COUNTER_WRAP_FLAG_EN
  logic wrap_q;
  logic wrap_d;

  // Pulse accompanies the all-ones -> zero step only when it comes from an increment.
  always_comb begin
    wrap_d = !load_en && (count_q == {N{1'b1}});
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_out = wrap_q;
`endif

endmodule

// File: tb/tb_parameterized_counter.sv
// Self-checking bench for parameterized_counter (N=8): directed steps then randomized traffic
// compared against an arithmetic reference model.
module tb_parameterized_counter;

  localparam int N = 8;
  localparam int MODV = 1 << N;

  logic         clk;
  logic         reset_n;
  logic         load_en;
  logic [N-1:0] data_in;
  logic [N-1:0] count_out;
`ifdef PARAMETERIZED_COUNTER_WRAP_FLAG_EN
  logic         wrap_out;
`endif

  int checks;
  int failures;
  int unsigned exp_cnt;
  int unsigned exp_wrap;

  parameterized_counter #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_en   (load_en),
    .data_in   (data_in),
`ifdef PARAMETERIZED_COUNTER_WRAP_FLAG_EN
    .wrap_out  (wrap_out),
`endif
    .count_out (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".count"}, {{(32-N){1'b0}}, count_out}, exp_cnt);
`ifdef PARAMETERIZED_COUNTER_WRAP_FLAG_EN
    chk({tag, ".wrap"}, {31'd0, wrap_out}, exp_wrap);
`endif
  endtask

  // Drive inputs away from the edge, take one rising edge, advance the model, compare.
  task automatic step(input logic rst, input logic ld, input logic [N-1:0] d, input string tag);
    reset_n = rst;
    load_en = ld;
    data_in = d;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_cnt  = 0;
      exp_wrap = 0;
    end else if (ld) begin
      exp_cnt  = d;
      exp_wrap = 0;
    end else begin
      exp_wrap = (exp_cnt == MODV - 1) ? 1 : 0;
      exp_cnt  = (exp_cnt + 1) % MODV;
    end
    chk_outputs(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    exp_wrap = 0;
    reset_n  = 1'b1;
    load_en  = 1'b0;
    data_in  = '0;

    #1;
    chk_outputs("reset_async_t0");

    step(1'b1, 1'b0, 8'h00, "reset_hold0");
    step(1'b1, 1'b0, 8'h00, "reset_hold1");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, "count_after_reset");

    step(1'b0, 1'b1, 8'h00, "load_zero");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, "count_after_load0");

    step(1'b0, 1'b1, 8'h38, "load_mid");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, "count_after_load38");

    step(1'b0, 1'b1, 8'hFF, "load_ff");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, "wrap_seq");

    step(1'b0, 1'b1, 8'h5A, "hold_load_a");
    step(1'b0, 1'b1, 8'h5A, "hold_load_b");

    // Async reset between edges must clear the count before the next edge.
    reset_n = 1'b1;
    #2;
    exp_cnt  = 0;
    exp_wrap = 0;
    chk_outputs("reset_async_mid");
    step(1'b1, 1'b0, 8'h00, "reset_mid_hold0");
    step(1'b1, 1'b1, 8'h77, "reset_beats_load");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, "count_after_mid_reset");

    step(1'b0, 1'b1, 8'hFF, "prio_load_ff");
    step(1'b0, 1'b1, 8'hAA, "prio_load_over_wrap");
    step(1'b0, 1'b0, 8'h00, "prio_after_aa");

    for (int i = 0; i < 400; i++) begin
      logic         r_rst;
      logic         r_ld;
      logic [N-1:0] r_d;
      r_rst = ($urandom_range(0, 31) == 0);
      r_ld  = ($urandom_range(0, 3) == 0);
      r_d   = ($urandom_range(0, 2) == 0) ? N'($urandom_range(MODV - 4, MODV - 1))
                                          : N'($urandom);
      step(r_rst, r_ld, r_d, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
